pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-synchronous game controller for the Pong display pipeline. Once per frame, at the start of vertical blanking, it advances the ball, resolves wall and paddle collisions, keeps score and sequences serve, play and game-over phases. Its registered ball and score outputs feed the downstream draw stages that follow the background stage. Because updates happen only at blanking start, those outputs are stable for the whole active picture.

## Interface
Parameters:
- H_ACTIVE, 800: visible width in pixels.
- V_ACTIVE, 600: visible height in lines.
- BALL_SIZE, 16: ball edge length in pixels.
- PADDLE_W, 10: paddle width.
- PADDLE_H, 80: paddle height.
- PADDLE_L_X, 20: left paddle left edge.
- PADDLE_R_X, 770: right paddle left edge.
- BALL_SPEED, 4: pixels per frame on each axis.
- SCORE_MAX, 5: points that end a game.
- SERVE_FRAMES, 30: frames the ball is held centred before play.

Ports:
- pclk  in  1: pixel clock. The block has one clock.
- rst_n  in  1: asynchronous, active-low reset.
- vblnk_in  in  1: vertical blank from the timing chain.
- start  in  1: debounced start level.
- paddle_l_y  in  11: top row of the left paddle.
- paddle_r_y  in  11: top row of the right paddle.
- ball_x  out  11: ball left column.
- ball_y  out  11: ball top row.
- ball_visible  out  1: ball is drawn.
- score_l  out  4: left player score.
- score_r  out  4: right player score.
- game_over  out  1: a game has ended.

## Operation
- frame_tick is vblnk_in & ~vblnk_q, where vblnk_q is vblnk_in registered. All state changes happen only on frame_tick.
- IDLE: ball hidden and centred. On frame_tick with start=1, clear both scores, load the serve counter with SERVE_FRAMES and go to SERVE.
- SERVE: ball visible at centre, x=(H_ACTIVE-BALL_SIZE)/2=392, y=(V_ACTIVE-BALL_SIZE)/2=292.
  - The counter decrements on each frame_tick.
  - On the tick where the counter is 1, go to PLAY. Motion starts on the next tick.
- PLAY: on each tick, compute nx = x ± BALL_SPEED and ny = y ± BALL_SPEED in 12-bit signed arithmetic.
  - Top wall: if ny ≤ 0, set y=0 and make dy positive (down).
  - Bottom wall: if ny+BALL_SIZE ≥ V_ACTIVE, set y=V_ACTIVE-BALL_SIZE and make dy negative (up).
  - Left paddle: applies when dx<0, nx ≤ PADDLE_L_X+PADDLE_W, x > PADDLE_L_X+PADDLE_W-1, and the paddle overlaps vertically. Overlap means y+BALL_SIZE > paddle_l_y and y < paddle_l_y+PADDLE_H, using the current y. Result: x=PADDLE_L_X+PADDLE_W and dx positive.
  - Right paddle: mirror of the left rule, with x=PADDLE_R_X-BALL_SIZE and dx negative.
  - Miss: if nx ≤ 0, right scores. If nx+BALL_SIZE ≥ H_ACTIVE, left scores.
  - The x and y rules are independent. A wall bounce and a paddle hit in the same tick both apply.
- Point scored:
  - Increment the scorer's score.
  - If the new score equals SCORE_MAX, go to GAME_OVER.
  - Otherwise centre the ball, keep dy, point dx toward the conceding player, reload the counter and go to SERVE.
- GAME_OVER: ball hidden, game_over=1, scores held. On frame_tick with start=1, clear scores and game_over, reload the counter and go to SERVE.
- start is ignored outside IDLE and GAME_OVER.
- Reset values, applied immediately while rst_n is low, including mid-play:
  - state IDLE
  - ball_x=392, ball_y=292, ball_visible=0
  - score_l=0, score_r=0, game_over=0
  - dx positive (right), dy positive (down)
  - counter 0, vblnk_q 0

## Timing
- All outputs are registered.
- Updates land on the first pclk edge that samples vblnk_in=1 with vblnk_q=0. Latency is one edge after vblnk_in rises.
- Exactly one update per frame. A vblnk_in held high produces no further ticks.
- Paddle inputs and start are sampled only at the tick edge.
- A rising vblnk_in in the first cycle after reset release is a valid tick.

## Structure
- Package pong_pkg holds:
  - state enum IDLE/SERVE/PLAY/GAME_OVER
  - default geometry constants
  - the centre-position constants
- Sub-module pong_ball_step (combinational) holds the next-position, wall, paddle and miss logic. It outputs next x/y/dx/dy plus score_l_hit and score_r_hit.
- pong_game_ctrl holds the FSM, serve counter, scores and output registers.

## Test plan
- Reset: hold rst_n low, then release and apply 3 ticks with start=0. Expect ball 392/292, visible 0, scores 0, game_over 0 throughout.
- Serve: start=1 for one tick, then 30 ticks. Expect visible=1 and the ball stationary through the serve phase. On the next tick the ball reaches 396/296.
- Bottom wall: ball reaches y=582 moving down. Next tick gives y=584 and dy up. The tick after gives y=580.
- Right paddle: paddle_r_y=250, ball at x=752, y=290 moving right. Next tick gives x=754 and dx left, and the score is unchanged.
- Right miss: paddle_r_y=0. The ball exits right and score_l becomes 1. The state is SERVE with the ball at 392/292 and dx right.
- Game over and mid-play reset:
  - Left reaches 5: expect game_over=1, visible=0, scores frozen.
  - start at a tick: expect SERVE with scores 0.
  - rst_n pulsed low mid-PLAY: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong frame controller.
// The centre helper is used to place the ball before every serve.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE     = 2'd1,
      PLAY      = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam int DEF_H_ACTIVE     = 800;
   localparam int DEF_V_ACTIVE     = 600;
   localparam int DEF_BALL_SIZE    = 16;
   localparam int DEF_PADDLE_W     = 10;
   localparam int DEF_PADDLE_H     = 80;
   localparam int DEF_PADDLE_L_X   = 20;
   localparam int DEF_PADDLE_R_X   = 770;
   localparam int DEF_BALL_SPEED   = 4;
   localparam int DEF_SCORE_MAX    = 5;
   localparam int DEF_SERVE_FRAMES = 30;

   localparam int CENTRE_X = (DEF_H_ACTIVE - DEF_BALL_SIZE) / 2;
   localparam int CENTRE_Y = (DEF_V_ACTIVE - DEF_BALL_SIZE) / 2;

   function automatic logic [10:0] centre(input int active, input int size);
      return 11'((active - size) / 2);
   endfunction

endpackage

// File: rtl/pong_ball_step.sv
// Combinational one-frame ball step: motion, wall bounces, paddle hits, misses.
// x and y rules are evaluated independently so a corner case applies both.
module pong_ball_step
   import pong_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int BALL_SIZE  = DEF_BALL_SIZE,
   parameter int PADDLE_W   = DEF_PADDLE_W,
   parameter int PADDLE_H   = DEF_PADDLE_H,
   parameter int PADDLE_L_X = DEF_PADDLE_L_X,
   parameter int PADDLE_R_X = DEF_PADDLE_R_X,
   parameter int BALL_SPEED = DEF_BALL_SPEED
) (
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        dx_pos,
   input  logic        dy_pos,
   input  logic [10:0] paddle_l_y,
   input  logic [10:0] paddle_r_y,
   output logic [10:0] next_x,
   output logic [10:0] next_y,
   output logic        next_dx_pos,
   output logic        next_dy_pos,
   output logic        score_l_hit,
   output logic        score_r_hit
);

   localparam logic signed [11:0] SPEED  = 12'(BALL_SPEED);
   localparam logic signed [11:0] SIZE   = 12'(BALL_SIZE);
   localparam logic signed [11:0] H_LIM  = 12'(H_ACTIVE);
   localparam logic signed [11:0] V_LIM  = 12'(V_ACTIVE);
   localparam logic signed [11:0] L_FACE = 12'(PADDLE_L_X + PADDLE_W);
   localparam logic signed [11:0] R_FACE = 12'(PADDLE_R_X);
   localparam logic [11:0]        SIZE_U = 12'(BALL_SIZE);
   localparam logic [11:0]        P_H    = 12'(PADDLE_H);
   localparam logic [10:0]        Y_FLOOR = 11'(V_ACTIVE - BALL_SIZE);
   localparam logic [10:0]        X_LHIT  = 11'(PADDLE_L_X + PADDLE_W);
   localparam logic [10:0]        X_RHIT  = 11'(PADDLE_R_X - BALL_SIZE);

   logic signed [11:0] sx, sy, nx, ny;
   logic [11:0]        y_top, y_bot;
   logic               overlap_l, overlap_r;

   assign sx = $signed({1'b0, x});
   assign sy = $signed({1'b0, y});
   assign nx = dx_pos ? sx + SPEED : sx - SPEED;
   assign ny = dy_pos ? sy + SPEED : sy - SPEED;

   // Vertical overlap uses the current row, before this frame's move.
   assign y_top     = {1'b0, y};
   assign y_bot     = y_top + SIZE_U;
   assign overlap_l = (y_bot > {1'b0, paddle_l_y}) && (y_top < {1'b0, paddle_l_y} + P_H);
   assign overlap_r = (y_bot > {1'b0, paddle_r_y}) && (y_top < {1'b0, paddle_r_y} + P_H);

   always_comb begin
      next_x      = x;
      next_y      = y;
      next_dx_pos = dx_pos;
      next_dy_pos = dy_pos;
      score_l_hit = 1'b0;
      score_r_hit = 1'b0;

      if (ny <= 12'sd0) begin
         next_y      = 11'd0;
         next_dy_pos = 1'b1;
      end else if (ny + SIZE >= V_LIM) begin
         next_y      = Y_FLOOR;
         next_dy_pos = 1'b0;
      end else begin
         next_y = ny[10:0];
      end

      // A paddle only catches a ball that has not already passed its face.
      if (!dx_pos && nx <= L_FACE && sx > L_FACE - 12'sd1 && overlap_l) begin
         next_x      = X_LHIT;
         next_dx_pos = 1'b1;
      end else if (dx_pos && nx + SIZE >= R_FACE && sx + SIZE <= R_FACE && overlap_r) begin
         next_x      = X_RHIT;
         next_dx_pos = 1'b0;
      end else if (nx <= 12'sd0) begin
         score_r_hit = 1'b1;
      end else if (nx + SIZE >= H_LIM) begin
         score_l_hit = 1'b1;
      end else begin
         next_x = nx[10:0];
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong controller: serve/play/game-over sequencing and scoring.
// Every state change lands on the edge that first sees vertical blanking rise.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int BALL_SIZE    = DEF_BALL_SIZE,
   parameter int PADDLE_W     = DEF_PADDLE_W,
   parameter int PADDLE_H     = DEF_PADDLE_H,
   parameter int PADDLE_L_X   = DEF_PADDLE_L_X,
   parameter int PADDLE_R_X   = DEF_PADDLE_R_X,
   parameter int BALL_SPEED   = DEF_BALL_SPEED,
   parameter int SCORE_MAX    = DEF_SCORE_MAX,
   parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        vblnk_in,
   input  logic        start,
   input  logic [10:0] paddle_l_y,
   input  logic [10:0] paddle_r_y,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic        ball_visible,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic        game_over,
   output state_t      state
);

   localparam logic [10:0] CX         = centre(H_ACTIVE, BALL_SIZE);
   localparam logic [10:0] CY         = centre(V_ACTIVE, BALL_SIZE);
   localparam logic [7:0]  SERVE_LOAD = 8'(SERVE_FRAMES);
   localparam logic [3:0]  SCORE_END  = 4'(SCORE_MAX);

   logic        vblnk_q, frame_tick;
   logic        dx_pos, dy_pos;
   logic [7:0]  serve_cnt;
   logic [10:0] step_x, step_y;
   logic        step_dx, step_dy, hit_l, hit_r, point_over;
   logic [3:0]  score_l_inc, score_r_inc;

   assign frame_tick  = vblnk_in & ~vblnk_q;
   assign score_l_inc = score_l + 4'd1;
   assign score_r_inc = score_r + 4'd1;
   assign point_over  = hit_l ? (score_l_inc == SCORE_END) : (score_r_inc == SCORE_END);

   pong_ball_step #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .BALL_SIZE (BALL_SIZE),
      .PADDLE_W  (PADDLE_W),
      .PADDLE_H  (PADDLE_H),
      .PADDLE_L_X(PADDLE_L_X),
      .PADDLE_R_X(PADDLE_R_X),
      .BALL_SPEED(BALL_SPEED)
   ) u_step (
      .x          (ball_x),
      .y          (ball_y),
      .dx_pos     (dx_pos),
      .dy_pos     (dy_pos),
      .paddle_l_y (paddle_l_y),
      .paddle_r_y (paddle_r_y),
      .next_x     (step_x),
      .next_y     (step_y),
      .next_dx_pos(step_dx),
      .next_dy_pos(step_dy),
      .score_l_hit(hit_l),
      .score_r_hit(hit_r)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         vblnk_q      <= 1'b0;
         ball_x       <= CX;
         ball_y       <= CY;
         ball_visible <= 1'b0;
         score_l      <= 4'd0;
         score_r      <= 4'd0;
         game_over    <= 1'b0;
         dx_pos       <= 1'b1;
         dy_pos       <= 1'b1;
         serve_cnt    <= 8'd0;
      end else begin
         vblnk_q <= vblnk_in;
         if (frame_tick) begin
            case (state)
               IDLE: begin
                  ball_x <= CX;
                  ball_y <= CY;
                  if (start) begin
                     score_l      <= 4'd0;
                     score_r      <= 4'd0;
                     serve_cnt    <= SERVE_LOAD;
                     ball_visible <= 1'b1;
                     state        <= SERVE;
                  end
               end
               SERVE: begin
                  if (serve_cnt <= 8'd1) begin
                     serve_cnt <= 8'd0;
                     state     <= PLAY;
                  end else begin
                     serve_cnt <= serve_cnt - 8'd1;
                  end
               end
               PLAY: begin
                  dy_pos <= step_dy;
                  if (hit_l || hit_r) begin
                     ball_x <= CX;
                     ball_y <= CY;
                     if (hit_l) score_l <= score_l_inc;
                     else       score_r <= score_r_inc;
                     if (point_over) begin
                        ball_visible <= 1'b0;
                        game_over    <= 1'b1;
                        state        <= GAME_OVER;
                     end else begin
                        // Next serve heads toward whoever just conceded.
                        dx_pos    <= hit_l;
                        serve_cnt <= SERVE_LOAD;
                        state     <= SERVE;
                     end
                  end else begin
                     ball_x <= step_x;
                     ball_y <= step_y;
                     dx_pos <= step_dx;
                  end
               end
               GAME_OVER: begin
                  if (start) begin
                     score_l      <= 4'd0;
                     score_r      <= 4'd0;
                     game_over    <= 1'b0;
                     ball_x       <= CX;
                     ball_y       <= CY;
                     ball_visible <= 1'b1;
                     serve_cnt    <= SERVE_LOAD;
                     state        <= SERVE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scenario bench for pong_game_ctrl: a full game with hand-traced ball
// positions, expectations queued per frame and checked by a blanking monitor.
module tb_pong_game_ctrl;
   import pong_pkg::*;

   logic        pclk = 1'b0;
   logic        rst_n, vblnk_in, start;
   logic [10:0] paddle_l_y, paddle_r_y;
   logic [10:0] ball_x, ball_y;
   logic        ball_visible, game_over;
   logic [3:0]  score_l, score_r;
   state_t      state;

   always #5 pclk = ~pclk;

   pong_game_ctrl dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .vblnk_in    (vblnk_in),
      .start       (start),
      .paddle_l_y  (paddle_l_y),
      .paddle_r_y  (paddle_r_y),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .ball_visible(ball_visible),
      .score_l     (score_l),
      .score_r     (score_r),
      .game_over   (game_over),
      .state       (state)
   );

   typedef struct packed {
      logic        chk;
      logic        chk_pos;
      logic [10:0] x;
      logic [10:0] y;
      logic        vis;
      logic [3:0]  sl;
      logic [3:0]  sr;
      logic        go;
      state_t      st;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic exp_t mk(input logic chk_pos, input int x, input int y, input logic vis,
                               input int sl, input int sr, input logic go, input state_t st);
      exp_t e;
      e.chk = 1'b1; e.chk_pos = chk_pos; e.x = 11'(x); e.y = 11'(y); e.vis = vis;
      e.sl = 4'(sl); e.sr = 4'(sr); e.go = go; e.st = st;
      return e;
   endfunction

   function automatic exp_t skip();
      exp_t e;
      e = '0;
      return e;
   endfunction

   task automatic compare(input exp_t e, input string tag);
      logic ok;
      n_checks++;
      ok = (ball_visible == e.vis) && (score_l == e.sl) && (score_r == e.sr) &&
           (game_over == e.go) && (state == e.st) &&
           (!e.chk_pos || (ball_x == e.x && ball_y == e.y));
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d vis=%0b sl=%0d sr=%0d go=%0b st=%s, need x=%0d y=%0d vis=%0b sl=%0d sr=%0d go=%0b st=%s (pos checked=%0b)",
                  tag, ball_x, ball_y, ball_visible, score_l, score_r, game_over, state.name(),
                  e.x, e.y, e.vis, e.sl, e.sr, e.go, e.st.name(), e.chk_pos);
      end
   endtask

   // One frame: caller is at a negedge; vblnk rises now and stays high for hold cycles.
   task automatic frame(input exp_t e, input string tag, input int hold);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      vblnk_in = 1'b1;
      repeat (hold) @(negedge pclk);
      vblnk_in = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic skip_frames(input int n);
      for (int i = 0; i < n; i++) frame(skip(), "skip", 1);
   endtask

   task automatic serve_frames(input int sl);
      for (int i = 0; i < 29; i++) frame(mk(1, 392, 292, 1, sl, 0, 0, SERVE), "serve_hold", 1);
      frame(mk(1, 392, 292, 1, sl, 0, 0, PLAY), "serve_end", 1);
   endtask

   // Monitor: one expectation is consumed per blanking rise seen out of reset.
   initial begin : monitor
      logic  prev;
      exp_t  e;
      string tag;
      prev = 1'b0;
      forever begin
         @(posedge pclk);
         if (rst_n && vblnk_in && !prev) begin
            prev = 1'b1;
            @(negedge pclk);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: got frame with no expectation queued, need none");
            end else begin
               e   = exp_q.pop_front();
               tag = tag_q.pop_front();
               if (e.chk) compare(e, tag);
            end
         end else begin
            prev = rst_n ? vblnk_in : 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      n_fail++;
      $display("FAIL timeout: got no end of test, need end within time budget");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst_n = 1'b0; vblnk_in = 1'b0; start = 1'b0;
      paddle_l_y = 11'd160; paddle_r_y = 11'd480;
      repeat (3) @(negedge pclk);
      compare(mk(1, 392, 292, 0, 0, 0, 0, IDLE), "reset_hold");
      rst_n = 1'b1;
      repeat (2) @(negedge pclk);

      for (int i = 0; i < 3; i++) frame(mk(1, 392, 292, 0, 0, 0, 0, IDLE), "idle", 3);
      start = 1'b1;
      frame(mk(1, 392, 292, 1, 0, 0, 0, SERVE), "serve_start", 3);
      start = 1'b0;
      serve_frames(0);

      // Play frame k: x = 392+4k, y = 292+4k until the floor at k=73.
      frame(mk(1, 396, 296, 1, 0, 0, 0, PLAY), "first_move", 2);
      skip_frames(70);
      frame(mk(1, 680, 580, 1, 0, 0, 0, PLAY), "bottom_approach", 1);
      frame(mk(1, 684, 584, 1, 0, 0, 0, PLAY), "bottom_clamp", 20);
      frame(mk(1, 688, 580, 1, 0, 0, 0, PLAY), "bottom_bounce", 1);
      skip_frames(15);
      frame(mk(1, 752, 516, 1, 0, 0, 0, PLAY), "rp_approach", 1);
      frame(mk(1, 754, 512, 1, 0, 0, 0, PLAY), "rp_hit", 1);
      frame(mk(1, 750, 508, 1, 0, 0, 0, PLAY), "rp_return", 1);

      // Heading left and up: top wall at 128 frames after the hit, left paddle at 181.
      skip_frames(178);
      frame(mk(1, 34, 208, 1, 0, 0, 0, PLAY), "lp_approach", 1);
      frame(mk(1, 30, 212, 1, 0, 0, 0, PLAY), "lp_hit", 1);
      paddle_r_y = 11'd1000;
      frame(mk(1, 34, 216, 1, 0, 0, 0, PLAY), "lp_return", 1);
      skip_frames(186);
      frame(mk(1, 782, 204, 1, 0, 0, 0, PLAY), "rmiss_approach", 1);
      frame(mk(1, 392, 292, 1, 1, 0, 0, SERVE), "rmiss_score", 1);

      for (int p = 2; p <= 5; p++) begin
         serve_frames(p - 1);
         if (p == 2) start = 1'b1;
         frame(mk(1, 396, (p % 2 == 0) ? 288 : 296, 1, p - 1, 0, 0, PLAY), "point_move", 1);
         start = 1'b0;
         skip_frames(95);
         frame(mk(1, 780, (p % 2 == 0) ? 96 : 488, 1, p - 1, 0, 0, PLAY), "point_approach", 1);
         if (p < 5) frame(mk(1, 392, 292, 1, p, 0, 0, SERVE), "point_score", 1);
         else       frame(mk(0, 0, 0, 0, 5, 0, 1, GAME_OVER), "game_end", 1);
      end

      frame(mk(0, 0, 0, 0, 5, 0, 1, GAME_OVER), "go_hold", 2);
      frame(mk(0, 0, 0, 0, 5, 0, 1, GAME_OVER), "go_hold", 2);
      start = 1'b1;
      frame(mk(1, 392, 292, 1, 0, 0, 0, SERVE), "restart", 2);
      start = 1'b0;
      serve_frames(0);
      for (int i = 0; i < 3; i++) frame(mk(0, 0, 0, 1, 0, 0, 0, PLAY), "replay", 1);

      #2;
      rst_n = 1'b0;
      #1;
      compare(mk(1, 392, 292, 0, 0, 0, 0, IDLE), "async_reset");
      @(negedge pclk);
      rst_n = 1'b1;
      start = 1'b1;
      frame(mk(1, 392, 292, 1, 0, 0, 0, SERVE), "tick_after_release", 2);
      start = 1'b0;
      repeat (4) @(negedge pclk);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d expectations left, need 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
